// File: rtl/div_ctrl.sv
// div_ctrl: round-robin scheduler that shares one multi-cycle unsigned
// shift-subtract divider between NUM_REQ requesters. It implements RISC-V
// DIV/DIVU/REM/REMU: the divider sees operand magnitudes, this block restores
// the result signs and answers divide-by-zero and signed overflow directly.
// Optional build macro DIV_CTRL_RESULT_CACHE_EN keeps the last divider result
// so that a repeated operand pair (e.g. DIV then REM) is answered in one cycle.
module div_ctrl #(
   parameter int XLEN    = 32,
   parameter int NUM_REQ = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*2-1:0]         req_op_i,
   input  logic [NUM_REQ*XLEN-1:0]      req_dividend_i,
   input  logic [NUM_REQ*XLEN-1:0]      req_divisor_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic                         rsp_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
   output logic [XLEN-1:0]              rsp_data_o,
   output logic                         busy_o,
   output logic                         div_start_o,
   output logic [XLEN-1:0]              div_dividend_o,
   output logic [XLEN-1:0]              div_divisor_o,
   input  logic                         div_done_i,
   input  logic [XLEN-1:0]              div_quotient_i,
   input  logic [XLEN-1:0]              div_remainder_i
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] div_dvd_q, div_dvd_d;
   logic [XLEN-1:0] div_dvs_q, div_dvs_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic            first_q, first_d;

   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic [1:0]      win_op;
   logic [XLEN-1:0] win_dvd, win_dvs;
   logic            win_signed, win_div0, win_ovf;
   logic            cache_hit;
   logic [XLEN-1:0] cache_data;
   logic [XLEN-1:0] quo_fix, rem_fix;

   // Round-robin pick: first set request above the pointer, wrapping around.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!win_found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
            win_found = 1'b1;
            win_id    = IDW'((int'(ptr_q) + i) % NUM_REQ);
         end
      end
   end

   // Winner's operands and the cases that never need the divider.
   always_comb begin
      win_op     = req_op_i[win_id*2 +: 2];
      win_dvd    = req_dividend_i[win_id*XLEN +: XLEN];
      win_dvs    = req_divisor_i[win_id*XLEN +: XLEN];
      win_signed = ~win_op[0];
      win_div0   = (win_dvs == '0);
      win_ovf    = win_signed && (win_dvd == INT_MIN) && (win_dvs == '1);
   end

   // Sign restoration of the unsigned divider result for signed ops.
   always_comb begin
      quo_fix = div_quotient_i;
      rem_fix = div_remainder_i;
      if (!op_q[0] && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1])) quo_fix = -div_quotient_i;
      if (!op_q[0] && dvd_q[XLEN-1])                   rem_fix = -div_remainder_i;
   end

`ifdef DIV_CTRL_RESULT_CACHE_EN
   logic            cache_valid_q;
   logic            cache_signed_q;
   logic [XLEN-1:0] cache_dvd_q, cache_dvs_q, cache_quo_q, cache_rem_q;
   logic            cache_wr;

   assign cache_wr = (state_q == S_WAIT) && !first_q && div_done_i;

   // Match the granted request against the last divider-path operands.
   always_comb begin
      cache_hit  = cache_valid_q && (cache_signed_q == win_signed) &&
                   (cache_dvd_q == win_dvd) && (cache_dvs_q == win_dvs);
      cache_data = win_op[1] ? cache_rem_q : cache_quo_q;
   end

   // Entry valid flag, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i)       cache_valid_q <= 1'b0;
      else if (cache_wr) cache_valid_q <= 1'b1;
   end

   // Entry payload, written whenever the divider returns a result.
   // NOTE: payload is storage guarded by the valid flag, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (cache_wr) begin
         cache_signed_q <= ~op_q[0];
         cache_dvd_q    <= dvd_q;
         cache_dvs_q    <= dvs_q;
         cache_quo_q    <= quo_fix;
         cache_rem_q    <= rem_fix;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_data = '0;
`endif

   // Next-state and output decode for the IDLE/ISSUE/WAIT/RESP sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      op_d       = op_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      div_dvd_d  = div_dvd_q;
      div_dvs_d  = div_dvs_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      first_d    = first_q;
      gnt_o      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_found && !reset_i) begin
               gnt_o[win_id] = 1'b1;
               ptr_d         = win_id;
               id_d          = win_id;
               op_d          = win_op;
               dvd_d         = win_dvd;
               dvs_d         = win_dvs;
               if (win_div0) begin
                  rsp_data_d = win_op[1] ? win_dvd : '1;
                  rsp_id_d   = win_id;
                  state_d    = S_RESP;
               end else if (win_ovf) begin
                  rsp_data_d = win_op[1] ? '0 : win_dvd;
                  rsp_id_d   = win_id;
                  state_d    = S_RESP;
               end else if (cache_hit) begin
                  rsp_data_d = cache_data;
                  rsp_id_d   = win_id;
                  state_d    = S_RESP;
               end else begin
                  div_dvd_d = (win_signed && win_dvd[XLEN-1]) ? -win_dvd : win_dvd;
                  div_dvs_d = (win_signed && win_dvs[XLEN-1]) ? -win_dvs : win_dvs;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            first_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done is still high from idle on the first WAIT cycle.
            if (first_q) begin
               first_d = 1'b0;
            end else if (div_done_i) begin
               rsp_data_d = op_q[1] ? rem_fix : quo_fix;
               rsp_id_d   = id_q;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= IDW'(NUM_REQ - 1);
         id_q       <= '0;
         op_q       <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         div_dvd_q  <= '0;
         div_dvs_q  <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         op_q       <= op_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         div_dvd_q  <= div_dvd_d;
         div_dvs_q  <= div_dvs_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         first_q    <= first_d;
      end
   end

   assign busy_o         = (state_q != S_IDLE);
   assign div_start_o    = (state_q == S_ISSUE);
   assign rsp_valid_o    = (state_q == S_RESP);
   assign rsp_data_o     = rsp_data_q;
   assign rsp_id_o       = rsp_id_q;
   assign div_dividend_o = div_dvd_q;
   assign div_divisor_o  = div_dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural Start/Done divider.
module tb_div_ctrl;

   localparam int XLEN    = 32;
   localparam int NUM_REQ = 2;
`ifdef DIV_CTRL_RESULT_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = '0;
   logic [3:0]  req_op = '0;
   logic [63:0] req_dvd = '0;
   logic [63:0] req_dvs = '0;
   logic [1:0]  gnt;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        busy;
   logic        div_start;
   logic [31:0] div_dividend, div_divisor;
   logic        div_done;
   logic [31:0] div_quotient, div_remainder;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   div_ctrl #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_i(req), .req_op_i(req_op), .req_dividend_i(req_dvd), .req_divisor_i(req_dvs),
      .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
      .busy_o(busy), .div_start_o(div_start),
      .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
      .div_done_i(div_done), .div_quotient_i(div_quotient), .div_remainder_i(div_remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: Done drops one cycle after Start, high again 33 cycles later.
   logic        m_start_q;
   int          m_cnt;
   logic [31:0] m_quo, m_rem;
   always @(posedge clk) begin
      if (reset) begin
         m_start_q <= 1'b0;
         m_cnt     <= 0;
         m_quo     <= '0;
         m_rem     <= '0;
      end else begin
         m_start_q <= div_start;
         if (div_start) begin
            m_quo <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            m_rem <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
         end
         if (m_start_q)      m_cnt <= 32;
         else if (m_cnt != 0) m_cnt <= m_cnt - 1;
      end
   end
   assign div_done      = (m_cnt == 0);
   assign div_quotient  = m_quo;
   assign div_remainder = m_rem;

   // Observation of divider starts and response pulses.
   int          start_cnt = 0;
   int          start_cyc = 0;
   logic [31:0] start_dvd = '0, start_dvs = '0;
   int          rsp_cnt = 0;
   always @(negedge clk) begin
      if (div_start) begin
         start_cnt = start_cnt + 1;
         start_cyc = cyc;
         start_dvd = div_dividend;
         start_dvs = div_divisor;
      end
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
   end

   // RISC-V M-extension reference.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   // Drive one request, wait for its grant and its response (both bounded).
   task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] data, output int rid,
                         output int t0, output int lat, output bit ok);
      int n;
      ok = 1'b0; data = '0; rid = -1; t0 = 0; lat = 0;
      @(posedge clk); #1;
      req_op[id*2 +: 2]   = op;
      req_dvd[id*32 +: 32] = a;
      req_dvs[id*32 +: 32] = b;
      req[id]              = 1'b1;
      n = 0;
      @(negedge clk);
      while (!gnt[id] && n < 200) begin @(negedge clk); n++; end
      if (!gnt[id]) begin req[id] = 1'b0; return; end
      t0 = cyc;
      @(posedge clk); #1;
      req[id] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      if (!rsp_valid) return;
      data = rsp_data;
      rid  = int'(rsp_id);
      lat  = cyc - t0;
      ok   = 1'b1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      req_op = 4'b0101;
      req_dvd = {32'd9, 32'd9};
      req_dvs = {32'd3, 32'd3};
      req    = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || div_start !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: busy=%b rsp_valid=%b div_start=%b expected 0 0 0", busy, rsp_valid, div_start); end
      checks++; if (rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
         errors++; $display("FAIL reset_rsp: data=%h id=%0d expected 0 0", rsp_data, rsp_id); end
      checks++; if (div_dividend !== 32'h0 || div_divisor !== 32'h0) begin
         errors++; $display("FAIL reset_divops: %h %h expected 0 0", div_dividend, div_divisor); end
      @(posedge clk); #1;
      req   = 2'b00;
      reset = 1'b0;
   endtask

   task automatic test_divu();
      logic [31:0] d; int rid, t0, lat; bit ok; exp_t e;
      exp_q.push_back('{0, ref_result(2'b01, 32'd100, 32'd7)});
      run_op(0, 2'b01, 32'd100, 32'd7, d, rid, t0, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL divu_timeout: got no response expected one"); end
      e = exp_q.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("FAIL divu_data: got %h expected %h", d, e.data); end
      checks++; if (rid !== e.id) begin errors++; $display("FAIL divu_id: got %0d expected %0d", rid, e.id); end
      checks++; if (lat !== 36) begin errors++; $display("FAIL divu_latency: got %0d expected 36", lat); end
      checks++; if (start_cyc !== t0 + 1) begin errors++; $display("FAIL divu_start_cycle: got %0d expected %0d", start_cyc, t0 + 1); end
      checks++; if (start_dvd !== 32'd100 || start_dvs !== 32'd7) begin
         errors++; $display("FAIL divu_start_ops: got %0d/%0d expected 100/7", start_dvd, start_dvs); end
   endtask

   task automatic test_signed();
      logic [1:0]  ops[4] = '{2'b10, 2'b00, 2'b00, 2'b10};
      logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] d; int rid, t0, lat; bit ok; exp_t e;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{1, ref_result(ops[k], as[k], bs[k])});
         run_op(1, ops[k], as[k], bs[k], d, rid, t0, lat, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || d !== e.data || rid !== e.id) begin
            errors++; $display("FAIL signed_%0d: got ok=%0d data=%h id=%0d expected data=%h id=%0d", k, ok, d, rid, e.data, e.id); end
         if (k == 0) begin
            checks++; if (start_dvd !== 32'd7 || start_dvs !== 32'd2) begin
               errors++; $display("FAIL signed_magnitudes: got %h/%h expected 7/2", start_dvd, start_dvs); end
         end
      end
   endtask

   task automatic test_special();
      logic [1:0]  ops[4] = '{2'b00, 2'b11, 2'b00, 2'b10};
      logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] d; int rid, t0, lat, starts; bit ok; exp_t e;
      starts = start_cnt;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{k % 2, ref_result(ops[k], as[k], bs[k])});
         run_op(k % 2, ops[k], as[k], bs[k], d, rid, t0, lat, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || d !== e.data || rid !== e.id) begin
            errors++; $display("FAIL special_%0d: got ok=%0d data=%h id=%0d expected data=%h id=%0d", k, ok, d, rid, e.data, e.id); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency_%0d: got %0d expected 1", k, lat); end
      end
      checks++; if (start_cnt !== starts) begin
         errors++; $display("FAIL special_no_start: got %0d starts expected 0", start_cnt - starts); end
   endtask

   task automatic test_round_robin();
      int n_gnt, n_rsp, exp_id; bit rsp_seen; exp_t e;
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      req_op  = {2'b10, 2'b01};
      req_dvd = {32'hFFFF_FF9C, 32'd1000};
      req_dvs = {32'd7, 32'd3};
      req     = 2'b11;
      n_gnt = 0; n_rsp = 0; rsp_seen = 1'b1;
      for (int c = 0; c < 400 && n_rsp < 4; c++) begin
         @(negedge clk);
         if (gnt !== 2'b00) begin
            exp_id = n_gnt % 2;
            checks++; if (gnt !== (2'b01 << exp_id)) begin
               errors++; $display("FAIL rr_order_%0d: got %b expected %b", n_gnt, gnt, 2'b01 << exp_id); end
            checks++; if (busy !== 1'b0 || !rsp_seen) begin
               errors++; $display("FAIL rr_idle_%0d: got busy=%b prior_rsp=%0d expected 0 1", n_gnt, busy, rsp_seen); end
            exp_q.push_back('{exp_id, ref_result(req_op[exp_id*2 +: 2], req_dvd[exp_id*32 +: 32], req_dvs[exp_id*32 +: 32])});
            n_gnt++;
            rsp_seen = 1'b0;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL rr_unexpected_rsp: got data=%h expected none", rsp_data);
            end else begin
               e = exp_q.pop_front();
               checks++; if (rsp_data !== e.data || int'(rsp_id) !== e.id) begin
                  errors++; $display("FAIL rr_rsp_%0d: got %h id %0d expected %h id %0d", n_rsp, rsp_data, rsp_id, e.data, e.id); end
            end
            n_rsp++;
            rsp_seen = 1'b1;
            if (n_rsp == 4) req = 2'b00;
         end
      end
      req = 2'b00;
      checks++; if (n_rsp != 4) begin errors++; $display("FAIL rr_timeout: got %0d responses expected 4", n_rsp); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int n, base; exp_t e;
      @(posedge clk); #1;
      req_op  = {2'b01, 2'b01};
      req_dvd = {32'd81, 32'd50};
      req_dvs = {32'd9, 32'd5};
      req     = 2'b01;
      n = 0;
      @(negedge clk);
      while (!gnt[0] && n < 200) begin @(negedge clk); n++; end
      checks++; if (!gnt[0]) begin errors++; $display("FAIL mid_grant: got %b expected 01", gnt); end
      base = rsp_cnt;
      @(posedge clk); #1; req = 2'b00;
      repeat (9) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
      @(posedge clk); #1;
      reset = 1'b1;
      req   = 2'b10;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL mid_after_reset: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid); end
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_pending_grant: got %b expected 10", gnt); end
      exp_q.push_back('{1, ref_result(2'b01, 32'd81, 32'd9)});
      @(posedge clk); #1; req = 2'b00;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++; if (!rsp_valid || rsp_data !== e.data || int'(rsp_id) !== e.id) begin
         errors++; $display("FAIL mid_rsp: got valid=%b %h id %0d expected %h id %0d", rsp_valid, rsp_data, rsp_id, e.data, e.id); end
      @(posedge clk);
      checks++; if (rsp_cnt - base !== 1) begin
         errors++; $display("FAIL mid_dropped: got %0d responses expected 1", rsp_cnt - base); end
   endtask

   task automatic test_cache();
      logic [31:0] d; int rid, t0, lat, starts, exp_lat; bit ok; exp_t e;
      exp_q.push_back('{0, ref_result(2'b01, 32'd100, 32'd7)});
      run_op(0, 2'b01, 32'd100, 32'd7, d, rid, t0, lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e.data || lat !== 36) begin
         errors++; $display("FAIL cache_first: got ok=%0d %h lat %0d expected %h lat 36", ok, d, lat, e.data); end
      starts = start_cnt;
      exp_lat = CACHE_EN ? 1 : 36;
      exp_q.push_back('{0, ref_result(2'b11, 32'd100, 32'd7)});
      run_op(0, 2'b11, 32'd100, 32'd7, d, rid, t0, lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL cache_data: got %h expected %h", d, e.data); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL cache_latency: got %0d expected %0d", lat, exp_lat); end
      checks++; if (start_cnt - starts !== (CACHE_EN ? 0 : 1)) begin
         errors++; $display("FAIL cache_starts: got %0d expected %0d", start_cnt - starts, CACHE_EN ? 0 : 1); end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_special();
      test_round_robin();
      test_reset_mid();
      test_cache();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
